// File: rtl/counter_arbiter_if.sv
// Bus between the requesters and the shared counter arbiter.
// The requester side drives requests and terminal counts. The arbiter
// side returns grant, completion, busy and the running count.
interface counter_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] limit0;
  logic [WIDTH-1:0] limit1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] q;

  modport master (
    output req, limit0, limit1,
    input  gnt, done, busy, q
  );

  modport slave (
    input  req, limit0, limit1,
    output gnt, done, busy, q
  );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that owns one up-counter shared by two requesters.
// The winner's terminal count is latched when the grant is issued. The count
// then runs from 0 to that limit while the grant is held, and a one-cycle DONE
// pulse is sent to the winner. If the owner drops its request mid-count, the
// count is aborted and no DONE is issued.
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  counter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] q_r;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic             busy_r;
  logic             own;    // index of the requester currently served
  logic             pri;    // requester that wins a simultaneous request
  logic             pick;   // winner if a grant happens this cycle

  // Choose the winner from the current request pattern.
  always_comb begin
    // NOTE: give every always_comb output a default first, so that a missed
    // branch cannot infer a latch.
    pick = 1'b0;
    case (bus.req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = pri;
      default: pick = 1'b0;
    endcase
  end

  // Arbitration and count sequencing. All outputs are registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so that every
    // register in this block samples the values from before the edge.
    if (reset) begin
      state  <= IDLE;
      lim    <= '0;
      q_r    <= '0;
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      busy_r <= 1'b0;
      own    <= 1'b0;
      pri    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          q_r   <= '0;
          gnt_r <= 2'b00;
          if (bus.req != 2'b00) begin
            own    <= pick;
            gnt_r  <= pick ? 2'b10 : 2'b01;
            lim    <= pick ? bus.limit1 : bus.limit0;
            busy_r <= 1'b1;
            state  <= COUNT;
          end
        end

        COUNT: begin
          if (!bus.req[own]) begin
            // An abort takes precedence over reaching the limit.
            gnt_r  <= 2'b00;
            q_r    <= '0;
            pri    <= ~own;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (q_r != lim) begin
            q_r <= q_r + WIDTH'(1);
          end else begin
            // Q holds at the limit through the DONE cycle.
            gnt_r  <= 2'b00;
            done_r <= own ? 2'b10 : 2'b01;
            state  <= FINISH;
          end
        end

        FINISH: begin
          done_r <= 2'b00;
          q_r    <= '0;
          pri    <= ~own;
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          q_r    <= '0;
          gnt_r  <= 2'b00;
          done_r <= 2'b00;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.q    = q_r;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter. Inputs change 1 time unit after each
// rising edge, and outputs are sampled at the same point.
module tb_counter_arbiter;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  counter_arbiter_if #(.WIDTH(WIDTH)) bus ();

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Safety net so that the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                            input logic b, input logic [3:0] qv);
    check({tag, ".gnt"},  32'(bus.gnt),  32'(g));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".q"},    32'(bus.q),    32'(qv));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] g;
    logic [3:0] l;

    // Reset held for 2 cycles while both requesters are requesting.
    reset      = 1'b1;
    bus.req    = 2'b11;
    bus.limit0 = 4'd5;
    bus.limit1 = 4'd9;
    tick(); expect_out("rst0", 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); expect_out("rst1", 2'b00, 2'b00, 1'b0, 4'd0);
    reset = 1'b0;

    // The first grant after reset goes to requester 0. The count then
    // continues as a single request with LIMIT0=5.
    tick(); expect_out("single.g", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      tick(); expect_out($sformatf("single.q%0d", i), 2'b01, 2'b00, 1'b1, 4'(i));
    end
    tick(); expect_out("single.done", 2'b00, 2'b01, 1'b1, 4'd5);
    bus.req = 2'b00;
    tick(); expect_out("single.idle", 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); expect_out("single.stay", 2'b00, 2'b00, 1'b0, 4'd0);

    // Zero limit on requester 1.
    bus.req    = 2'b10;
    bus.limit1 = 4'd0;
    tick(); expect_out("zero.g", 2'b10, 2'b00, 1'b1, 4'd0);
    tick(); expect_out("zero.done", 2'b00, 2'b10, 1'b1, 4'd0);
    bus.req = 2'b00;
    tick(); expect_out("zero.idle", 2'b00, 2'b00, 1'b0, 4'd0);

    // Round-robin with both requesters held high. Grants go 0,1,0,1, and
    // there are 2 cycles from each DONE to the next GNT.
    bus.req    = 2'b11;
    bus.limit0 = 4'd2;
    bus.limit1 = 4'd3;
    for (int r = 0; r < 4; r++) begin
      g = (r % 2 == 1) ? 2'b10 : 2'b01;
      l = (r % 2 == 1) ? 4'd3 : 4'd2;
      tick(); expect_out($sformatf("rr%0d.g", r), g, 2'b00, 1'b1, 4'd0);
      for (int c = 1; c <= int'(l); c++) begin
        tick(); expect_out($sformatf("rr%0d.q%0d", r, c), g, 2'b00, 1'b1, 4'(c));
      end
      tick(); expect_out($sformatf("rr%0d.done", r), 2'b00, g, 1'b1, l);
      if (r == 3) bus.req = 2'b00;
      tick(); expect_out($sformatf("rr%0d.idle", r), 2'b00, 2'b00, 1'b0, 4'd0);
    end

    // Abort: requester 0 drops its request at Q=3.
    bus.req    = 2'b01;
    bus.limit0 = 4'd9;
    tick(); expect_out("abort.g", 2'b01, 2'b00, 1'b1, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      tick(); expect_out($sformatf("abort.q%0d", i), 2'b01, 2'b00, 1'b1, 4'(i));
    end
    bus.req = 2'b00;
    tick(); expect_out("abort.drop", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b11;
    tick(); expect_out("abort.next", 2'b10, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b00;
    tick(); expect_out("abort.next_drop", 2'b00, 2'b00, 1'b0, 4'd0);

    // A change to LIMIT0 in mid-count is ignored, so the count still reaches 7.
    bus.req    = 2'b01;
    bus.limit0 = 4'd7;
    tick(); expect_out("lim.g", 2'b01, 2'b00, 1'b1, 4'd0);
    tick(); expect_out("lim.q1", 2'b01, 2'b00, 1'b1, 4'd1);
    bus.limit0 = 4'd2;
    for (int i = 2; i <= 7; i++) begin
      tick(); expect_out($sformatf("lim.q%0d", i), 2'b01, 2'b00, 1'b1, 4'(i));
    end
    tick(); expect_out("lim.done", 2'b00, 2'b01, 1'b1, 4'd7);
    bus.req = 2'b00;
    tick(); expect_out("lim.idle", 2'b00, 2'b00, 1'b0, 4'd0);

    // Reset in mid-count at Q=4. No DONE may appear, and the priority
    // pointer (now 1) must return to requester 0.
    bus.req    = 2'b01;
    bus.limit0 = 4'd7;
    tick(); expect_out("rstmid.g", 2'b01, 2'b00, 1'b1, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(); expect_out($sformatf("rstmid.q%0d", i), 2'b01, 2'b00, 1'b1, 4'(i));
    end
    reset = 1'b1;
    tick(); expect_out("rstmid.rst", 2'b00, 2'b00, 1'b0, 4'd0);
    reset   = 1'b0;
    bus.req = 2'b00;
    tick(); expect_out("rstmid.after", 2'b00, 2'b00, 1'b0, 4'd0);
    bus.req = 2'b11;
    tick(); expect_out("rstmid.pri", 2'b01, 2'b00, 1'b1, 4'd0);
    bus.req = 2'b00;
    tick(); expect_out("rstmid.end", 2'b00, 2'b00, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
